// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multicycle instruction-fetch sequencer feeding the instruction register
// Owns the fetch PC, issues word reads over req/valid and pulses the IR enable once per fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] ir_instr,
  output logic [1:0]  ir_control,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_done,
  output logic        misaligned_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [31:0] ir_instr_q, ir_instr_d;
  logic [31:0] addr_eff;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    mem_rd_addr_d = mem_rd_addr_q;
    ir_instr_d    = ir_instr_q;
    // A redirect presented with fetch_start takes effect for that same fetch.
    addr_eff      = pc_write ? pc_next : fetch_pc_q;

    case (state_q)
      IDLE: begin
        if (pc_write) begin
          fetch_pc_d = pc_next;
        end
        if (fetch_start) begin
          if (addr_eff[1:0] == 2'b00) begin
            mem_rd_addr_d = addr_eff;
            state_d       = WAIT;
          end else begin
            state_d = ERR;
          end
        end
      end
      WAIT: begin
        if (mem_rd_valid) begin
          ir_instr_d = mem_rd_data;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        pc_d       = mem_rd_addr_q;
        fetch_pc_d = mem_rd_addr_q + 32'd4;
        state_d    = IDLE;
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      mem_rd_addr_q <= RESET_PC;
      ir_instr_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      ir_instr_q    <= ir_instr_d;
    end
  end

  // The IR enable is suppressed under reset so clear and load never coincide.
  assign fetch_done     = (state_q == LOAD) && !reset;
  assign ir_control     = {reset, fetch_done};
  assign mem_rd_req     = (state_q == WAIT);
  assign mem_rd_addr    = mem_rd_addr_q;
  assign ir_instr       = ir_instr_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign misaligned_err = (state_q == ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
// Transaction-level expectations, compared against the DUT on every falling edge.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_start = 1'b0;
  logic        pc_write = 1'b0;
  logic [31:0] pc_next = 32'd0;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = 32'd0;
  logic [31:0] ir_instr;
  logic [1:0]  ir_control;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_done;
  logic        misaligned_err;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_start   (fetch_start),
    .pc_write      (pc_write),
    .pc_next       (pc_next),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .ir_instr      (ir_instr),
    .ir_control    (ir_control),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_done    (fetch_done),
    .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic        exp_req = 1'b0;
  logic [31:0] exp_addr = RST_PC;
  logic [31:0] exp_instr = 32'd0;
  logic [1:0]  exp_ctrl = 2'b10;
  logic [31:0] exp_pc = RST_PC;
  logic        exp_done = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] m_fetch_pc = RST_PC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_rd_req", {31'd0, mem_rd_req}, {31'd0, exp_req});
      check("mem_rd_addr", mem_rd_addr, exp_addr);
      check("ir_instr", ir_instr, exp_instr);
      check("ir_control", {30'd0, ir_control}, {30'd0, exp_ctrl});
      check("pc", pc, exp_pc);
      check("pc_plus4", pc_plus4, exp_pc + 32'd4);
      check("fetch_done", {31'd0, fetch_done}, {31'd0, exp_done});
      check("misaligned_err", {31'd0, misaligned_err}, {31'd0, exp_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    exp_ctrl = 2'b10;
    for (int i = 0; i < n; i++) begin
      tick();
      exp_req = 1'b0; exp_addr = RST_PC; exp_instr = 32'd0;
      exp_pc = RST_PC; exp_done = 1'b0; exp_err = 1'b0;
      m_fetch_pc = RST_PC;
      chk_en = 1'b1;
    end
    reset = 1'b0;
    exp_ctrl = 2'b00;
  endtask

  // One aligned fetch: memory answers after d wait cycles; optionally a redirect is
  // attempted (and must be ignored) during the first WAIT cycle.
  task automatic do_fetch(input logic redir, input logic [31:0] target, input int d,
                          input logic [31:0] data, input logic wait_redir);
    logic [31:0] a;
    a = redir ? target : m_fetch_pc;
    fetch_start = 1'b1; pc_write = redir; pc_next = target;
    tick();
    fetch_start = 1'b0; pc_write = 1'b0;
    exp_req = 1'b1; exp_addr = a;
    for (int i = 0; i <= d; i++) begin
      mem_rd_valid = (i == d);
      mem_rd_data  = (i == d) ? data : (32'hBAD0_0000 + i);
      if (i == 0 && wait_redir) begin
        pc_write = 1'b1; pc_next = 32'h0000_3000; fetch_start = 1'b1;
      end
      tick();
      pc_write = 1'b0; fetch_start = 1'b0;
    end
    mem_rd_valid = 1'b0;
    exp_req = 1'b0; exp_instr = data; exp_done = 1'b1; exp_ctrl = 2'b01;
    tick();
    exp_done = 1'b0; exp_ctrl = 2'b00; exp_pc = a; m_fetch_pc = a + 32'd4;
  endtask

  initial begin
    // Reset and first zero-wait fetch
    do_reset(2);
    do_fetch(1'b0, 32'd0, 0, 32'h0050_0093, 1'b0);
    check("lit_first_pc", pc, 32'h0000_1000);
    check("lit_first_pc4", pc_plus4, 32'h0000_1004);
    check("lit_first_instr", ir_instr, 32'h0050_0093);

    // Back-to-back fetches with 0, 3 and 7 wait cycles
    do_reset(1);
    do_fetch(1'b0, 32'd0, 0, 32'h1111_0001, 1'b0);
    do_fetch(1'b0, 32'd0, 3, 32'h2222_0002, 1'b0);
    do_fetch(1'b0, 32'd0, 7, 32'h3333_0003, 1'b0);
    check("lit_b2b_pc", pc, 32'h0000_1008);

    // Redirect together with fetch_start, then an ignored redirect during WAIT
    do_fetch(1'b1, 32'h0000_2040, 1, 32'h4444_0004, 1'b0);
    check("lit_redir_pc", pc, 32'h0000_2040);
    do_fetch(1'b0, 32'd0, 2, 32'h5555_0005, 1'b1);
    check("lit_ignored_redir_pc", pc, 32'h0000_2044);

    // Wrap-around at the top of the address space
    do_fetch(1'b1, 32'hFFFF_FFFC, 0, 32'h6666_0006, 1'b0);
    check("lit_wrap_pc4", pc_plus4, 32'h0000_0000);
    do_fetch(1'b0, 32'd0, 0, 32'h7777_0007, 1'b0);
    check("lit_wrap_next_pc", pc, 32'h0000_0000);

    // Misaligned redirect: sticky error, no request, later starts ignored
    fetch_start = 1'b1; pc_write = 1'b1; pc_next = 32'h0000_1002;
    tick();
    pc_write = 1'b0;
    exp_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rd_valid = 1'b1; mem_rd_data = 32'hCAFE_0000 + i;
      tick();
    end
    fetch_start = 1'b0; mem_rd_valid = 1'b0;
    check("lit_err_sticky", {31'd0, misaligned_err}, 32'd1);
    do_reset(1);
    check("lit_err_cleared", {31'd0, misaligned_err}, 32'd0);

    // Reset while a read is outstanding; the late valid must be ignored
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    exp_req = 1'b1; exp_addr = RST_PC;
    tick();
    tick();
    do_reset(2);
    mem_rd_valid = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
    tick();
    mem_rd_valid = 1'b0;
    tick();
    check("lit_late_valid_instr", ir_instr, 32'h0000_0000);
    do_fetch(1'b0, 32'd0, 1, 32'h8888_0008, 1'b0);
    check("lit_after_reset_pc", pc, 32'h0000_1000);
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
